sar_search_controller: RTL and testbench
========================================

// Module: sar_search_controller
// PURPOSE
//  Successive-approximation search engine that drives the operand side of a
//  magnitude comparator and consumes its LT/GT/EQ answers. It binary-searches
//  MSB-first for the hidden operand held on the comparator's other input.
//  Used wherever a value is only observable through compare results
//  (threshold search, SAR ADC control, table lookup by bisection).
// PARAMETERS
//  WIDTH    8  probe/result width in bits (>=2)
//  CMP_LAT  0  extra cycles between a probe change and a valid comparator answer
// PORTS
//  i_CLK     in   1      clock; all logic on rising edge
//  i_RST     in   1      synchronous, active-high reset
//  i_START   in   1      start a search; sampled only in IDLE
//  i_LT      in   1      comparator: o_PROBE <  target
//  i_GT      in   1      comparator: o_PROBE >  target
//  i_EQ      in   1      comparator: o_PROBE == target
//  o_PROBE   out  WIDTH  registered operand presented to the comparator
//  o_BUSY    out  1      search in progress
//  o_DONE    out  1      one-cycle pulse: o_RESULT/o_FOUND/o_ERR are valid
//  o_RESULT  out  WIDTH  search result; held until the next accepted start
//  o_FOUND   out  1      EQ was observed for o_RESULT
//  o_ERR     out  1      sticky: a sampled {LT,GT,EQ} was not one-hot
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, bit index and wait counter cleared.
//   Reset mid-search aborts it; no o_DONE is issued.
//  FSM: IDLE -> PROBE -> (WAIT x CMP_LAT) -> DECIDE -> PROBE ... | VERIFY -> DONE -> IDLE.
//  IDLE: i_START=1 at edge 0 -> o_PROBE={1,0..0}, o_BUSY=1, o_ERR=0,
//   o_FOUND=0, bit index = WIDTH-1. i_START while busy or in DONE is ignored.
//  Each probe is held for CMP_LAT+1 cycles; the comparator is sampled on the
//   last of them. Probe k (k=1..) is visible in cycles (k-1)(L+1)+1..k(L+1),
//   with L=CMP_LAT.
//  Decision at bit b (priority EQ > GT > LT):
//   EQ -> o_RESULT=o_PROBE, o_FOUND=1, go DONE (early exit).
//   GT -> clear bit b; LT -> keep bit b; then, if b>0, set bit b-1 and continue.
//   None asserted: treated as LT. Non-one-hot vector: o_ERR=1 (sticky).
//  After bit 0 without EQ: VERIFY presents the final value as one more probe
//   (same L+1 hold). EQ -> o_FOUND=1, else 0. o_RESULT = final value.
//  DONE: o_DONE=1 for exactly one cycle, o_BUSY=0 in that cycle, then IDLE.
//   o_PROBE keeps its last value until the next start.
//  Latency: EQ at probe k -> o_DONE in cycle k(L+1)+1.
//   Worst case (WIDTH bit probes plus VERIFY) -> cycle (WIDTH+1)(L+1)+1.
//  A monotone target always gives o_FOUND=1. An inconsistent comparator
//   gives o_FOUND=0 and the greatest value not answered GT.
// TESTING (WIDTH=8, CMP_LAT=0 unless stated; start at cycle 0; model = ideal comparator)
//  target 0xA5 -> probes 80,C0,A0,B0,A8,A4,A6,A5; o_DONE cycle 9, RESULT=A5, FOUND=1
//  target 0x00 -> probes 80..01 all GT, verify 00 EQ; o_DONE cycle 10, RESULT=00, FOUND=1
//  target 0x80 -> EQ on first probe; o_DONE cycle 2, RESULT=80, BUSY low from cycle 2
//  i_LT tied 1, i_GT=i_EQ=0 -> RESULT=FF, FOUND=0, ERR=0, o_DONE cycle 10
//  LT=GT=1 on first sample -> ERR=1, held to DONE; next start clears ERR
//  i_RST at cycle 4 -> cycle 5 all outputs 0, IDLE, no DONE; i_START pulses during busy ignored
//  CMP_LAT=2, target 0x00 -> each probe held 3 cycles; o_DONE cycle 28

Source files
------------

// File: rtl/sar_search_controller.sv
// sar_search_controller
// Successive-approximation search engine. Drives a probe operand into an
// external magnitude comparator and bisects MSB-first on its LT/GT/EQ
// answers until the hidden operand is found or every bit has been decided.
// A final VERIFY probe confirms the result when no early EQ occurred.
module sar_search_controller #(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_START,
    input  logic             i_LT,
    input  logic             i_GT,
    input  logic             i_EQ,
    output logic [WIDTH-1:0] o_PROBE,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [WIDTH-1:0] o_RESULT,
    output logic             o_FOUND,
    output logic             o_ERR
);

    localparam int BW = $clog2(WIDTH);
    localparam int WW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

    localparam logic [BW-1:0]    MSB_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    BIT_ONE = BW'(1);
    localparam logic [BW-1:0]    BIT_ZERO = BW'(0);
    localparam logic [WW-1:0]    LAT_C   = WW'(CMP_LAT);
    localparam logic [WW-1:0]    WAIT_ONE = WW'(1);
    localparam logic [WW-1:0]    WAIT_ZERO = WW'(0);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_W   = ONE_W << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [BW-1:0]    r_bit;
    logic [WW-1:0]    r_wait;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic             r_err;

    logic             w_sample;
    logic             w_bad_vec;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_kept;
    logic [WIDTH-1:0] w_next_probe;

    // A legal comparator answer has exactly one of LT/GT/EQ set.
    function automatic logic is_one_hot(input logic [2:0] v);
        case (v)
            3'b001, 3'b010, 3'b100: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Bit-decision arithmetic: drop bit b on GT, then trial-set bit b-1.
    always_comb begin
        w_sample     = (r_wait == LAT_C);
        w_bad_vec    = ~is_one_hot({i_LT, i_GT, i_EQ});
        w_bit_mask   = ONE_W << r_bit;
        if (i_GT) begin
            w_kept = r_probe & ~w_bit_mask;
        end else begin
            w_kept = r_probe;
        end
        w_next_probe = w_kept | (w_bit_mask >> 1);
    end

    // Search FSM; the hold counter stretches each probe to CMP_LAT+1 cycles.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state  <= S_IDLE;
            r_bit    <= BIT_ZERO;
            r_wait   <= WAIT_ZERO;
            r_probe  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_START) begin
                        r_probe <= MSB_W;
                        r_bit   <= MSB_BIT;
                        r_wait  <= WAIT_ZERO;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_found <= 1'b0;
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (!w_sample) begin
                        r_wait <= r_wait + WAIT_ONE;
                    end else begin
                        r_wait <= WAIT_ZERO;
                        if (w_bad_vec) begin
                            r_err <= 1'b1;
                        end
                        if (i_EQ) begin
                            // Exact hit: finish early without a verify probe.
                            r_result <= r_probe;
                            r_found  <= 1'b1;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else if (r_bit != BIT_ZERO) begin
                            r_probe <= w_next_probe;
                            r_bit   <= r_bit - BIT_ONE;
                        end else begin
                            r_probe <= w_kept;
                            r_state <= S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    if (!w_sample) begin
                        r_wait <= r_wait + WAIT_ONE;
                    end else begin
                        r_wait <= WAIT_ZERO;
                        if (w_bad_vec) begin
                            r_err <= 1'b1;
                        end
                        r_result <= r_probe;
                        r_found  <= i_EQ;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Single-cycle completion pulse; START here is ignored.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_PROBE  = r_probe;
    assign o_BUSY   = r_busy;
    assign o_DONE   = r_done;
    assign o_RESULT = r_result;
    assign o_FOUND  = r_found;
    assign o_ERR    = r_err;

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller: table of searches against a comparator
// model, scoreboard of expected results, plus reset / hold / restart cases.
module tb_sar_search_controller;

    typedef struct {
        logic [7:0] res;
        logic       found;
        logic       err;
        int         cyc;
    } exp_t;

    typedef struct {
        int         sel;
        int         mode;
        logic [7:0] tgt;
        logic [7:0] res;
        logic       found;
        logic       err;
        int         cyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start0, start1;
    logic [7:0] probe0, probe1, res0, res1;
    logic       busy0, done0, found0, err0, busy1, done1, found1, err1;
    logic       lt0, gt0, eq0, lt1, gt1, eq1;

    int         sel  = 0;
    int         mode = 0;
    logic [7:0] tgt  = 8'h00;

    logic [7:0] w_probe, w_res;
    logic       w_busy, w_done, w_found, w_err;

    int n_pass  = 0;
    int n_total = 0;

    exp_t       sb[$];
    logic [7:0] probe_log[$];

    // Comparator model: 0 ideal, 1 LT stuck high, 2 LT+GT on probe 0x80.
    function automatic logic [2:0] cmp_model(input int m, input logic [7:0] p, input logic [7:0] t);
        logic [2:0] ideal;
        ideal = {p < t, p > t, p == t};
        case (m)
            1:       return 3'b100;
            2:       return (p == 8'h80) ? 3'b110 : ideal;
            default: return ideal;
        endcase
    endfunction

    always_comb {lt0, gt0, eq0} = cmp_model(mode, probe0, tgt);
    always_comb {lt1, gt1, eq1} = cmp_model(mode, probe1, tgt);

    always_comb begin
        if (sel == 1) begin
            {w_probe, w_res, w_busy, w_done, w_found, w_err} = {probe1, res1, busy1, done1, found1, err1};
        end else begin
            {w_probe, w_res, w_busy, w_done, w_found, w_err} = {probe0, res0, busy0, done0, found0, err0};
        end
    end

    sar_search_controller #(.WIDTH(8), .CMP_LAT(0)) u_dut0 (
        .i_CLK(clk), .i_RST(rst), .i_START(start0),
        .i_LT(lt0), .i_GT(gt0), .i_EQ(eq0),
        .o_PROBE(probe0), .o_BUSY(busy0), .o_DONE(done0),
        .o_RESULT(res0), .o_FOUND(found0), .o_ERR(err0)
    );

    sar_search_controller #(.WIDTH(8), .CMP_LAT(2)) u_dut1 (
        .i_CLK(clk), .i_RST(rst), .i_START(start1),
        .i_LT(lt1), .i_GT(gt1), .i_EQ(eq1),
        .o_PROBE(probe1), .o_BUSY(busy1), .o_DONE(done1),
        .o_RESULT(res1), .o_FOUND(found1), .o_ERR(err1)
    );

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) begin
            start1 = v;
            start0 = 1'b0;
        end else begin
            start0 = v;
            start1 = 1'b0;
        end
    endtask

    // Start a search at cycle 0 and follow it to o_DONE.
    // pulse_cyc: extra START pulse in that cycle; hold_cyc: START kept high through it.
    task automatic run_search(input int s, input int m, input logic [7:0] t, input exp_t e,
                              input int pulse_cyc, input int hold_cyc);
        int   cyc;
        int   busy_bad;
        logic seen;
        logic [7:0] held;
        exp_t got;
        sel = s; mode = m; tgt = t;
        sb.push_back(e);
        probe_log.delete();
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        cyc = 1; busy_bad = 0; seen = 1'b0; held = 8'h00;
        while (cyc < 200) begin
            set_start((cyc <= hold_cyc) || (cyc == pulse_cyc));
            if (cyc == 1) begin
                check("c1_probe", w_probe, 8'h80);
                check("c1_err_found", {w_err, w_found}, 2'b00);
            end
            if (w_done) begin
                seen = 1'b1;
                break;
            end
            probe_log.push_back(w_probe);
            if (!w_busy) busy_bad++;
            @(negedge clk);
            cyc++;
        end
        if (seen && sb.size() > 0) begin
            got = sb.pop_front();
            check("done_cycle", cyc, got.cyc);
            check("result", w_res, got.res);
            check("found", w_found, got.found);
            check("err", w_err, got.err);
            check("busy_at_done", w_busy, 0);
            check("busy_during", busy_bad, 0);
            held = w_probe;
        end else begin
            check("done_timeout", int'(seen), 0 + 2);
            sb.delete();
        end
        @(negedge clk);
        set_start(1'b0);
        check("done_pulse", w_done, 0);
        check("probe_hold", w_probe, held);
        check("busy_after", w_busy, 0);
        @(negedge clk);
        check("busy_after2", w_busy, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int   nd;
        exp_t e;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dut0", {probe0, busy0, done0, res0, found0, err0}, 0);
        check("reset_dut1", {probe1, busy1, done1, res1, found1, err1}, 0);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{0, 0, 8'hA5, 8'hA5, 1'b1, 1'b0, 9});
        vecs.push_back('{0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 10});
        vecs.push_back('{0, 0, 8'h80, 8'h80, 1'b1, 1'b0, 2});
        vecs.push_back('{0, 1, 8'h3C, 8'hFF, 1'b0, 1'b0, 10});
        vecs.push_back('{0, 2, 8'h33, 8'h33, 1'b1, 1'b1, 9});
        vecs.push_back('{0, 0, 8'h33, 8'h33, 1'b1, 1'b0, 9});
        vecs.push_back('{0, 0, 8'hFF, 8'hFF, 1'b1, 1'b0, 9});
        vecs.push_back('{0, 0, 8'h01, 8'h01, 1'b1, 1'b0, 9});
        vecs.push_back('{0, 0, 8'hC0, 8'hC0, 1'b1, 1'b0, 3});
        vecs.push_back('{1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 28});
        vecs.push_back('{1, 0, 8'hA5, 8'hA5, 1'b1, 1'b0, 25});

        foreach (vecs[i]) begin
            e = '{vecs[i].res, vecs[i].found, vecs[i].err, vecs[i].cyc};
            run_search(vecs[i].sel, vecs[i].mode, vecs[i].tgt, e, 0, 0);
        end

        // Probe sequence for 0xA5 with a START pulse in cycle 3 that must be ignored.
        e = '{8'hA5, 1'b1, 1'b0, 9};
        run_search(0, 0, 8'hA5, e, 3, 0);
        begin
            logic [7:0] exp_seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
            check("a5_log_len", probe_log.size(), 8);
            for (int i = 0; i < 8 && i < probe_log.size(); i++) begin
                check($sformatf("a5_probe%0d", i + 1), probe_log[i], exp_seq[i]);
            end
        end

        // CMP_LAT=2: each probe held three cycles.
        e = '{8'h00, 1'b1, 1'b0, 28};
        run_search(1, 0, 8'h00, e, 0, 0);
        check("lat2_log_len", probe_log.size(), 27);
        if (probe_log.size() >= 4) begin
            check("lat2_hold", {probe_log[0], probe_log[1], probe_log[2], probe_log[3]}, 32'h80808040);
        end

        // START held high through the DONE cycle must not restart the search.
        e = '{8'h80, 1'b1, 1'b0, 2};
        run_search(0, 0, 8'h80, e, 0, 2);

        // Reset in cycle 4 aborts the search; no DONE follows.
        sel = 0; mode = 0; tgt = 8'h5A;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("ignored_start_probe", probe0, 8'h60);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midsearch_reset", {probe0, busy0, done0, res0, found0, err0}, 0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) nd++;
        end
        check("no_done_after_reset", nd, 0);
        check("idle_after_reset", {busy0, probe0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
